// File: rtl/uart_hex_line_receiver_pkg.sv
// Shared definitions for the UART hex line receiver: ASCII control codes,
// RX state encoding and the hex digit decoder.
package uart_hex_line_receiver_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } hex_digit_t;

    // Both letter ranges have low nibble 1..6, so value = low nibble + 9.
    function automatic hex_digit_t hex_decode(input logic [7:0] c);
        hex_digit_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r.nibble = c[3:0];
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r.nibble = c[3:0] + 4'd9;
        end else begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_hex_line_receiver_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, down-counting bit timer and RX FSM
// producing one registered byte/pulse per frame.
module uart_hex_line_receiver_rx_core
    import uart_hex_line_receiver_pkg::*;
#(
    parameter int CLK_DIVIDER = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(CLK_DIVIDER);
    localparam logic [TW-1:0] HALF_BIT  = TW'(CLK_DIVIDER / 2 - 1);
    localparam logic [TW-1:0] FULL_BIT  = TW'(CLK_DIVIDER - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic            sync1_q, sync2_q;
    rx_state_t       state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_s;

    assign rx_s = sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            timer_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        // Every timed state just counts down until the timer reads zero.
        if (state_q != IDLE && state_q != WAIT_HIGH && timer_q != '0) begin
            timer_d = timer_q - TIMER_ONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        timer_d = HALF_BIT;
                        state_d = START;
                    end
                end
                START: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        timer_d   = FULL_BIT;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    timer_d   = FULL_BIT;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (rx_s) begin
                        byte_data_d  = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign byte_data  = byte_data_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_hex_line_receiver.sv
// Debug UART receive path: deserialises bytes and parses newline-terminated
// ASCII hex lines (MSB nibble first) into a WIDTH-bit register.
module uart_hex_line_receiver
    import uart_hex_line_receiver_pkg::*;
#(
    parameter int CLK_DIVIDER = 200,
    parameter int WIDTH       = 96
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    output logic             frame_err,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             hex_err
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = $clog2(DIGITS) + 1;
    localparam logic [CW-1:0] DIGITS_C = CW'(DIGITS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [7:0]       rx_byte;
    logic             rx_valid;
    hex_digit_t       dig;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bad_q, bad_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             hex_err_q, hex_err_d;

    uart_hex_line_receiver_rx_core #(
        .CLK_DIVIDER(CLK_DIVIDER)
    ) u_rx_core (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (frame_err)
    );

    assign dig = hex_decode(rx_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            bad_q        <= 1'b0;
            ovf_q        <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            hex_err_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            bad_q        <= bad_d;
            ovf_q        <= ovf_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            hex_err_q    <= hex_err_d;
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        bad_d        = bad_q;
        ovf_d        = ovf_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        hex_err_d    = 1'b0;
        if (rx_valid) begin
            if (rx_byte == ASCII_LF) begin
                if (cnt_q == DIGITS_C && !bad_q && !ovf_q) begin
                    data_d       = acc_q;
                    data_valid_d = 1'b1;
                end else begin
                    hex_err_d = 1'b1;
                end
                acc_d = '0;
                cnt_d = '0;
                bad_d = 1'b0;
                ovf_d = 1'b0;
            end else if (rx_byte == ASCII_CR || bad_q) begin
                // CR is transparent; a poisoned line waits for its LF.
            end else if (dig.valid) begin
                if (cnt_q == DIGITS_C) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d = {acc_q[WIDTH-5:0], dig.nibble};
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    assign byte_data  = rx_byte;
    assign byte_valid = rx_valid;
    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign hex_err    = hex_err_q;

endmodule

// File: tb/tb_uart_hex_line_receiver.sv
// Directed plus randomized bench for uart_hex_line_receiver with a line-level
// reference model.
module tb_uart_hex_line_receiver;

    localparam int DIV = 8;
    localparam int W   = 96;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx = 1'b1;
    logic [7:0]   byte_data;
    logic         byte_valid;
    logic         frame_err;
    logic [W-1:0] data;
    logic         data_valid;
    logic         hex_err;

    always #5 clk = ~clk;

    uart_hex_line_receiver #(
        .CLK_DIVIDER(DIV),
        .WIDTH      (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .data       (data),
        .data_valid (data_valid),
        .hex_err    (hex_err)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] rxq[$];
    int fe_cnt = 0;
    int dv_cnt = 0;
    int he_cnt = 0;
    logic [7:0] line_q[$];
    logic [W-1:0] exp_data;

    always @(negedge clk) begin
        if (byte_valid) rxq.push_back(byte_data);
        if (frame_err)  fe_cnt++;
        if (data_valid) dv_cnt++;
        if (hex_err)    he_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_bits(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV);
    endtask

    task automatic send_byte(input logic [7:0] b);
        frame_bits(b, 1'b1);
        rx = 1'b1;
        tick(2 * DIV);
    endtask

    task automatic load_str(input string s);
        line_q.delete();
        for (int i = 0; i < s.len(); i++) line_q.push_back(s[i]);
    endtask

    task automatic send_line();
        foreach (line_q[i]) send_byte(line_q[i]);
        send_byte(8'h0A);
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hexchar(input int v, input bit upper);
        if (v < 10) return 8'(48 + v);
        return upper ? 8'(55 + v) : 8'(87 + v);
    endfunction

    // A line is good when, ignoring CRs, it holds exactly W/4 hex digits.
    function automatic bit line_model(output logic [W-1:0] val);
        int n = 0;
        bit bad = 0;
        val = '0;
        foreach (line_q[i]) begin
            if (line_q[i] == 8'h0D) continue;
            if (hexval(line_q[i]) < 0) bad = 1;
            else begin
                n++;
                val = val * 16 + W'(hexval(line_q[i]));
            end
        end
        return !bad && n == W / 4;
    endfunction

    task automatic line_check(input string tag);
        logic [W-1:0] val;
        bit ok;
        int dv0, he0;
        ok  = line_model(val);
        dv0 = dv_cnt;
        he0 = he_cnt;
        send_line();
        if (ok) exp_data = val;
        check({tag, "_dv"},   128'(dv_cnt - dv0), 128'(ok));
        check({tag, "_herr"}, 128'(he_cnt - he0), 128'(!ok));
        check({tag, "_data"}, 128'(data), 128'(exp_data));
        $display("line %s: %0d bytes ok=%0d data=%h", tag, line_q.size(), ok, data);
    endtask

    initial begin
        logic [7:0] rb[4];
        int he0, dv0, fe0, nb0;
        int kind, n, p;
        logic [7:0] c;

        // Reset state
        reset = 1'b1;
        tick(5);
        @(negedge clk);
        check("rst_byte_data", 128'(byte_data), 128'h0);
        check("rst_data", 128'(data), 128'h0);
        check("rst_pulses", 128'({byte_valid, frame_err, data_valid, hex_err}), 128'h0);
        reset = 1'b0;
        tick(2 * DIV);

        // 1: byte reception
        rxq.delete();
        send_byte(8'h55);
        send_byte(8'hA3);
        for (int i = 0; i < 4; i++) begin
            rb[i] = 8'($urandom_range(0, 255));
            send_byte(rb[i]);
        end
        check("t1_count", 128'(rxq.size()), 128'd6);
        check("t1_b0", 128'(rxq.size() > 0 ? rxq[0] : 8'hxx), 128'h55);
        check("t1_b1", 128'(rxq.size() > 1 ? rxq[1] : 8'hxx), 128'hA3);
        for (int i = 0; i < 4; i++)
            check("t1_rand", 128'(rxq.size() > i + 2 ? rxq[i + 2] : 8'hxx), 128'(rb[i]));
        check("t1_ferr", 128'(fe_cnt), 128'd0);
        $display("t1: received %0d bytes", rxq.size());

        // 2: framing error and break
        rxq.delete();
        fe0 = fe_cnt;
        frame_bits(8'h41, 1'b0);
        rx = 1'b0;
        tick(30 * DIV);
        rx = 1'b1;
        tick(2 * DIV);
        check("t2_ferr", 128'(fe_cnt - fe0), 128'd1);
        check("t2_nobyte", 128'(rxq.size()), 128'd0);
        send_byte(8'h42);
        check("t2_recover", 128'(rxq.size() == 1 ? rxq[0] : 8'hxx), 128'h42);
        $display("t2: frame_err=%0d bytes=%0d", fe_cnt - fe0, rxq.size());

        // 3: false start
        rxq.delete();
        fe0 = fe_cnt;
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(4 * DIV);
        check("t3_nobyte", 128'(rxq.size()), 128'd0);
        check("t3_noferr", 128'(fe_cnt - fe0), 128'd0);
        $display("t3: false start bytes=%0d", rxq.size());

        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2 * DIV);
        exp_data = '0;

        // 4: valid mixed-case line with CR
        load_str("0123456789ABCDEFabcdef01");
        line_q.push_back(8'h0D);
        line_check("t4");
        check("t4_const", 128'(data), 128'(96'h0123456789ABCDEFABCDEF01));

        // 5: malformed lines keep previous data
        load_str("0123456789ABCDEF0123456");
        line_check("t5_short");
        load_str("0123456789ABCDEF012345678");
        line_check("t5_long");
        load_str("0123G56789ABCDEF01234567");
        line_check("t5_bad");
        check("t5_keep", 128'(data), 128'(96'h0123456789ABCDEFABCDEF01));

        // 6: reset in bit 4 of a byte mid-line
        send_byte("1");
        send_byte("2");
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(DIV);
        end
        tick(DIV / 2);
        reset = 1'b1;
        rx = 1'b1;
        dv0 = dv_cnt;
        he0 = he_cnt;
        fe0 = fe_cnt;
        nb0 = rxq.size();
        tick(3);
        @(negedge clk);
        check("t6_rst_data", 128'(data), 128'h0);
        check("t6_rst_byte", 128'(byte_data), 128'h0);
        check("t6_rst_pulses", 128'({byte_valid, frame_err, data_valid, hex_err}), 128'h0);
        reset = 1'b0;
        exp_data = '0;
        tick(4 * DIV);
        check("t6_no_pulse", 128'({dv_cnt - dv0, he_cnt - he0, fe_cnt - fe0, rxq.size() - nb0}), 128'h0);
        load_str("FFFFFFFFFFFFFFFFFFFFFFFF");
        line_check("t6_ones");
        check("t6_all_ones", 128'(data), 128'({W{1'b1}}));

        // Random lines against the reference model
        for (int l = 0; l < 8; l++) begin
            kind = $urandom_range(0, 5);
            line_q.delete();
            n = (kind == 1) ? $urandom_range(1, 23) :
                (kind == 2) ? $urandom_range(25, 27) :
                (kind == 4) ? 0 : 24;
            for (int i = 0; i < n; i++)
                line_q.push_back(hexchar($urandom_range(0, 15), 1'($urandom_range(0, 1))));
            if (kind == 3) begin
                p = $urandom_range(0, 23);
                do c = 8'($urandom_range(0, 255));
                while (hexval(c) >= 0 || c == 8'h0A || c == 8'h0D);
                line_q[p] = c;
            end
            if ($urandom_range(0, 1) == 1) line_q.push_back(8'h0D);
            line_check($sformatf("rand%0d_k%0d", l, kind));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
